dfx_data_send: RTL and testbench

DFX_DATA_SEND -- requirements
Module: dfx_data_send

---
 rtl/dfx_data_send.sv | 200 ++++++++++++++++++++
 tb/tb_dfx_data_send.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfx_data_send.sv
// -----------------------------------------------------------------------------
// dfx_data_send
//
// Transmit-side flit buffer: a DEPTH-entry circular buffer followed by a single
// output register driven by a two-state IDLE/SEND FSM. Upstream pushes flits
// with write_enable. The receive side pulls them with a valid/ready handshake at
// one flit per cycle. A write that arrives while the buffer is full is dropped
// and latches the sticky overflow flag.
//
// Optional feature (compile-time macro DFX_SEND_PKT_CNT_EN):
//   adds output sent_cnt, a 32-bit wrapping count of completed handshakes.
//
// Parameters
//   DATA_W : flit width. Default 1034, with [1033:1024] the header and
//            [1023:0] the payload.
//   DEPTH  : number of buffer entries. Must be a power of two, minimum 2.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   write_enable in   push data_in this cycle
//   data_in      in   flit to transmit
//   full         out  buffer holds DEPTH entries
//   overflow     out  sticky: a write was dropped (cleared only by rst)
//   tx_valid     out  tx_data holds a valid flit
//   tx_data      out  flit presented to the receive side
//   tx_ready     in   receive side accepts tx_data this cycle
//   count        out  buffer occupancy, not counting the output register
//   sent_cnt     out  (DFX_SEND_PKT_CNT_EN only) completed handshakes
// -----------------------------------------------------------------------------
module dfx_data_send #(
    parameter int unsigned DATA_W = 1034,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write_enable,
    input  logic [DATA_W-1:0]       data_in,
    output logic                    full,
    output logic                    overflow,
    output logic                    tx_valid,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_ready,
    output logic [$clog2(DEPTH):0]  count
`ifdef DFX_SEND_PKT_CNT_EN
    ,
    output logic [31:0]             sent_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // The pointers carry one bit above the index. Equal indices with differing
    // MSBs means full, and identical pointers means empty.
    localparam logic [PTR_W:0] PtrOne = 1;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StSend = 1'b1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]    wptr_q, wptr_d;
    logic [PTR_W:0]    rptr_q, rptr_d;
    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              overflow_q, overflow_d;

    // -------------------------------------------------------------------------
    // Buffer status
    // -------------------------------------------------------------------------
    logic empty;
    logic full_int;
    logic push;
    logic pop;

    assign empty    = (wptr_q == rptr_q);
    assign full_int = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                      (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);

    // Full is judged on the registered pointers. A pop in the same cycle does
    // not make room for a write that arrives while the buffer is full.
    assign push = write_enable && !full_int;

    // -------------------------------------------------------------------------
    // Output-register FSM
    // -------------------------------------------------------------------------
    // The head is read from the registered buffer state only. A flit written
    // this cycle therefore cannot reach tx_data before the next edge.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop       = 1'b1;
                    tx_data_d = mem_q[rptr_q[PTR_W-1:0]];
                    state_d   = StSend;
                end
            end
            StSend: begin
                // While stalled, nothing changes, so tx_data stays stable.
                if (tx_ready) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        tx_data_d = mem_q[rptr_q[PTR_W-1:0]];
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Pointer and flag next state
    // -------------------------------------------------------------------------
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;
        if (push) begin
            wptr_d = wptr_q + PtrOne;
        end
        if (pop) begin
            rptr_d = rptr_q + PtrOne;
        end
        if (write_enable && full_int) begin
            overflow_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            state_q    <= StIdle;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset. Only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[PTR_W-1:0]] <= data_in;
        end
    end

    // -------------------------------------------------------------------------
    // Optional handshake counter
    // -------------------------------------------------------------------------
`ifdef DFX_SEND_PKT_CNT_EN
    logic [31:0] sent_cnt_q, sent_cnt_d;

    // Wraps naturally from all-ones to zero.
    always_comb begin
        sent_cnt_d = sent_cnt_q;
        if (tx_valid && tx_ready) begin
            sent_cnt_d = sent_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent_cnt_q <= '0;
        end else begin
            sent_cnt_q <= sent_cnt_d;
        end
    end

    assign sent_cnt = sent_cnt_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // tx_valid decodes the state register directly. An asynchronous reset
    // therefore drops it at once.
    assign tx_valid = (state_q == StSend);
    assign tx_data  = tx_data_q;
    assign full     = full_int;
    assign overflow = overflow_q;
    assign count    = wptr_q - rptr_q;

endmodule

// File: tb/tb_dfx_data_send.sv
`timescale 1ns/1ps
module tb_dfx_data_send;

    localparam int DATA_W = 1034;
    localparam int DEPTH  = 8;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int NV     = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              write_enable;
    logic [DATA_W-1:0] data_in;
    logic              full;
    logic              overflow;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic [CW-1:0]     count;
`ifdef DFX_SEND_PKT_CNT_EN
    logic [31:0]       sent_cnt;
`endif

    dfx_data_send #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .data_in      (data_in),
        .full         (full),
        .overflow     (overflow),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
`ifdef DFX_SEND_PKT_CNT_EN
        .sent_cnt     (sent_cnt),
`endif
        .count        (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got hdr=%h low=%h, want hdr=%h low=%h @%0t", name,
                     act[DATA_W-1 -: 10], act[63:0], exp[DATA_W-1 -: 10], exp[63:0], $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(input int i);
        logic [31:0] w;
        w  = 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
        mk = {(10'(i) ^ 10'h155), {32{w}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard. Outputs are sampled on the falling
    // edge, which lies between input changes and the next rising edge.
    // ------------------------------------------------------------------
    int                mcount = 0;
    bit                mvalid = 1'b0;
    bit                movf   = 1'b0;
    logic [31:0]       msent  = '0;
    int                rx_cnt = 0;
    logic [DATA_W-1:0] sb [$];

    initial begin
        forever begin
            bit hs, acc, pp;
            @(negedge clk);
            if (rst) begin
                mcount = 0;
                mvalid = 1'b0;
                movf   = 1'b0;
                msent  = '0;
                sb.delete();
            end else begin
                chk("mon tx_valid", DATA_W'(tx_valid), DATA_W'(mvalid));
                chk("mon count", DATA_W'(count), DATA_W'(mcount));
                chk("mon full", DATA_W'(full), DATA_W'(mcount == DEPTH));
                chk("mon overflow", DATA_W'(overflow), DATA_W'(movf));
`ifdef DFX_SEND_PKT_CNT_EN
                chk("mon sent_cnt", DATA_W'(sent_cnt), DATA_W'(msent));
`endif
                hs = mvalid && tx_ready;
                if (hs) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL mon unexpected flit: got low=%h, want none", tx_data[63:0]);
                    end else begin
                        chk("mon tx_data", tx_data, sb.pop_front());
                    end
                    rx_cnt++;
                    msent++;
                end
                acc = write_enable && (mcount < DEPTH);
                if (write_enable && mcount == DEPTH) movf = 1'b1;
                if (acc) sb.push_back(data_in);
                pp     = (mcount > 0) && (!mvalid || tx_ready);
                mcount = mcount + int'(acc) - int'(pp);
                if (pp) mvalid = 1'b1;
                else if (hs) mvalid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed vectors: inputs applied before an edge, outputs after it
    // ------------------------------------------------------------------
    typedef struct {
        logic              we;
        logic [DATA_W-1:0] din;
        logic              rdy;
        logic              ev;
        logic [CW-1:0]     ec;
        logic              cd;
        logic [DATA_W-1:0] ed;
    } vec_t;

    vec_t vt [NV];

    function automatic vec_t mv(input logic we, input logic [DATA_W-1:0] din,
                                input logic rdy, input logic ev, input int ec,
                                input logic cd, input logic [DATA_W-1:0] ed);
        vec_t v;
        v.we  = we;
        v.din = din;
        v.rdy = rdy;
        v.ev  = ev;
        v.ec  = CW'(ec);
        v.cd  = cd;
        v.ed  = ed;
        return v;
    endfunction

    initial begin
        logic [DATA_W-1:0] single;
        int                sent;
        int                maxc;
        single = {10'h2A5, 1024'h2A5};

        // Single flit.
        vt[0] = mv(1'b1, single, 1'b1, 1'b0, 1, 1'b0, '0);
        vt[1] = mv(1'b0, '0,     1'b1, 1'b1, 0, 1'b1, single);
        vt[2] = mv(1'b0, '0,     1'b1, 1'b0, 0, 1'b0, '0);
        // Backpressure: three flits, then release.
        vt[3] = mv(1'b1, mk(0),  1'b0, 1'b0, 1, 1'b0, '0);
        vt[4] = mv(1'b1, mk(1),  1'b0, 1'b1, 1, 1'b1, mk(0));
        vt[5] = mv(1'b1, mk(2),  1'b0, 1'b1, 2, 1'b1, mk(0));
        vt[6] = mv(1'b0, '0,     1'b0, 1'b1, 2, 1'b1, mk(0));
        vt[7] = mv(1'b0, '0,     1'b1, 1'b1, 1, 1'b1, mk(1));
        vt[8] = mv(1'b0, '0,     1'b1, 1'b1, 0, 1'b1, mk(2));
        vt[9] = mv(1'b0, '0,     1'b1, 1'b0, 0, 1'b0, '0);

        rst          = 1'b1;
        write_enable = 1'b0;
        data_in      = '0;
        tx_ready     = 1'b0;
        #1;
        chk("reset tx_valid", DATA_W'(tx_valid), '0);
        chk("reset tx_data", tx_data, '0);
        chk("reset count", DATA_W'(count), '0);
        chk("reset full", DATA_W'(full), '0);
        chk("reset overflow", DATA_W'(overflow), '0);
        tick();
        tick();
        rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            write_enable = vt[k].we;
            data_in      = vt[k].din;
            tx_ready     = vt[k].rdy;
            tick();
            chk($sformatf("vec%0d tx_valid", k), DATA_W'(tx_valid), DATA_W'(vt[k].ev));
            chk($sformatf("vec%0d count", k), DATA_W'(count), DATA_W'(vt[k].ec));
            chk($sformatf("vec%0d full", k), DATA_W'(full), '0);
            chk($sformatf("vec%0d overflow", k), DATA_W'(overflow), '0);
            if (vt[k].cd) chk($sformatf("vec%0d tx_data", k), tx_data, vt[k].ed);
        end
        write_enable = 1'b0;

        // Full and overflow under backpressure.
        rx_cnt   = 0;
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            write_enable = 1'b1;
            data_in      = mk(100 + i);
            tick();
        end
        chk("fill full", DATA_W'(full), DATA_W'(1));
        chk("fill count", DATA_W'(count), DATA_W'(DEPTH));
        chk("fill overflow", DATA_W'(overflow), DATA_W'(1));

        // Full buffer, pop and write in the same cycle: write is dropped.
        write_enable = 1'b1;
        data_in      = mk(200);
        tx_ready     = 1'b1;
        tick();
        chk("simul count", DATA_W'(count), DATA_W'(DEPTH - 1));
        chk("simul full", DATA_W'(full), '0);
        chk("simul overflow", DATA_W'(overflow), DATA_W'(1));
        write_enable = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!mvalid && mcount == 0) break;
            tick();
        end
        tick();
        // Flits 100..108 get through. The dropped ones never show up.
        chk("drain received", DATA_W'(rx_cnt), DATA_W'(DEPTH + 1));
        chk("drain overflow sticky", DATA_W'(overflow), DATA_W'(1));
        chk("drain tx_valid", DATA_W'(tx_valid), '0);

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset clears overflow", DATA_W'(overflow), '0);

        // Wrap-around stream with toggling ready.
        rx_cnt = 0;
        sent   = 0;
        maxc   = 0;
        for (int c = 0; c < 2000; c++) begin
            if (rx_cnt >= 3 * DEPTH) break;
            tx_ready = c[0];
            if (sent < 3 * DEPTH && mcount < DEPTH) begin
                write_enable = 1'b1;
                data_in      = mk(300 + sent);
                sent++;
            end else begin
                write_enable = 1'b0;
            end
            tick();
            if (int'(count) > maxc) maxc = int'(count);
        end
        write_enable = 1'b0;
        tx_ready     = 1'b1;
        tick();
        chk("stream received", DATA_W'(rx_cnt), DATA_W'(3 * DEPTH));
        chk("stream count bound", DATA_W'(maxc <= DEPTH), DATA_W'(1));
        chk("stream reached full", DATA_W'(maxc), DATA_W'(DEPTH));
        chk("stream no overflow", DATA_W'(overflow), '0);

        // Asynchronous reset while SEND is stalled with count=5.
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            write_enable = 1'b1;
            data_in      = mk(400 + i);
            tick();
        end
        write_enable = 1'b0;
        chk("pre-reset count", DATA_W'(count), DATA_W'(5));
        chk("pre-reset tx_valid", DATA_W'(tx_valid), DATA_W'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("async rst tx_valid", DATA_W'(tx_valid), '0);
        chk("async rst count", DATA_W'(count), '0);
        chk("async rst full", DATA_W'(full), '0);
`ifdef DFX_SEND_PKT_CNT_EN
        chk("async rst sent_cnt", DATA_W'(sent_cnt), '0);
`endif
        tick();
        rst      = 1'b0;
        tx_ready = 1'b1;
        tick();
        tick();
        chk("post-reset tx_valid", DATA_W'(tx_valid), '0);
        chk("post-reset count", DATA_W'(count), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
